// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter.
//   DEF_WIDTH / DEF_NREG : default data width and register count
//   req_id_e             : identifies the two writeback requesters
//   arb_state_e          : arbiter FSM states
//   addr_width()         : address width for a given register count
package reg_write_arbiter_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREG  = 16;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no write issued last cycle
    ST_WRITE = 2'd1,  // a write was issued last cycle
    ST_STALL = 2'd2   // hold was high while a request was waiting
  } arb_state_e;

  // A single-entry bank still needs a one-bit address port.
  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_onehot_decode.sv
// Address to one-hot enable decoder.
//   i_addr   : register address
//   i_en     : decode enable; all outputs are 0 when low
//   o_onehot : one bit per register, set for the addressed entry
// Addresses at or above NREG match no entry, so they decode to all-zero.
module onehot_decode
  import reg_write_arbiter_pkg::*;
#(
  parameter int NREG = DEF_NREG,
  parameter int AW   = addr_width(DEF_NREG)
) (
  input  logic [AW-1:0]   i_addr,
  input  logic            i_en,
  output logic [NREG-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      o_onehot[i] = i_en && (i_addr == AW'(i));
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Two-requester writeback arbiter in front of a register bank.
//   i_clock, i_reset         : clock, asynchronous active-high reset
//   i_hold                   : sequencer stall, blocks all grants
//   i_alu_req/addr/data      : ALU writeback request
//   o_alu_gnt                : ALU request accepted this cycle
//   i_ld_req/addr/data       : load writeback request
//   o_ld_gnt                 : load request accepted this cycle
//   o_wr_en                  : registered one-hot bank write enable
//   o_wr_data                : registered data broadcast to the bank
//   o_pend_cnt               : registered count of waiting requests
//
// Handshake: a requester holds req/addr/data stable from req rise until the
// cycle its gnt is 1; gnt is combinational in that same cycle and the write
// appears on o_wr_en/o_wr_data for exactly one cycle after the next edge.
// Ties go to the requester not granted most recently.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NREG    = DEF_NREG,
  parameter int LOCK_R0 = 1
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic                         i_hold,
  input  logic                         i_alu_req,
  input  logic [addr_width(NREG)-1:0]  i_alu_addr,
  input  logic [WIDTH-1:0]             i_alu_data,
  output logic                         o_alu_gnt,
  input  logic                         i_ld_req,
  input  logic [addr_width(NREG)-1:0]  i_ld_addr,
  input  logic [WIDTH-1:0]             i_ld_data,
  output logic                         o_ld_gnt,
  output logic [NREG-1:0]              o_wr_en,
  output logic [WIDTH-1:0]             o_wr_data,
  output logic [1:0]                   o_pend_cnt
);

  localparam int AW = addr_width(NREG);

  arb_state_e       r_state;
  req_id_e          r_last;
  logic [NREG-1:0]  r_wr_en;
  logic [WIDTH-1:0] r_wr_data;
  logic [1:0]       r_pend;

  logic             w_open;
  logic             w_alu_gnt;
  logic             w_ld_gnt;
  logic             w_any_gnt;
  logic [AW-1:0]    w_sel_addr;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_locked;
  logic [NREG-1:0]  w_onehot;
  logic [1:0]       w_pend;

  // Grants are forced low during reset so nothing is accepted in that cycle.
  assign w_open    = !i_reset && !i_hold;
  assign w_alu_gnt = w_open && i_alu_req && (!i_ld_req || (r_last == REQ_LD));
  assign w_ld_gnt  = w_open && i_ld_req && (!i_alu_req || (r_last == REQ_ALU));
  assign w_any_gnt = w_alu_gnt || w_ld_gnt;

  assign w_sel_addr = w_alu_gnt ? i_alu_addr : i_ld_addr;
  assign w_sel_data = w_alu_gnt ? i_alu_data : i_ld_data;

  // Register 0 can be write-protected: the grant completes but no enable fires.
  assign w_locked = (LOCK_R0 != 0) && (w_sel_addr == '0);

  assign w_pend = {1'b0, i_alu_req && !w_alu_gnt} + {1'b0, i_ld_req && !w_ld_gnt};

  onehot_decode #(
    .NREG (NREG),
    .AW   (AW)
  ) u_decode (
    .i_addr   (w_sel_addr),
    .i_en     (w_any_gnt && !w_locked),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_last    <= REQ_LD;
      r_wr_en   <= '0;
      r_wr_data <= '0;
      r_pend    <= '0;
    end else begin
      r_wr_en <= w_onehot;
      r_pend  <= w_pend;
      if (w_any_gnt) begin
        r_wr_data <= w_sel_data;
        r_last    <= w_alu_gnt ? REQ_ALU : REQ_LD;
      end
      if (i_hold && (i_alu_req || i_ld_req)) begin
        r_state <= ST_STALL;
      end else if (w_any_gnt) begin
        r_state <= ST_WRITE;
      end else begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign o_alu_gnt  = w_alu_gnt;
  assign o_ld_gnt   = w_ld_gnt;
  // Enables are only presented in the cycle following an issued write.
  assign o_wr_en    = (r_state == ST_WRITE) ? r_wr_en : '0;
  assign o_wr_data  = r_wr_data;
  assign o_pend_cnt = r_pend;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (WIDTH=16, NREG=16, LOCK_R0=1).
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold = 1'b0;
  logic        alu_req = 1'b0;
  logic [3:0]  alu_addr = '0;
  logic [15:0] alu_data = '0;
  logic        alu_gnt;
  logic        ld_req = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        ld_gnt;
  logic [15:0] wr_en;
  logic [15:0] wr_data;
  logic [1:0]  pend_cnt;

  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  reg_write_arbiter #(
    .WIDTH   (16),
    .NREG    (16),
    .LOCK_R0 (1)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_hold     (hold),
    .i_alu_req  (alu_req),
    .i_alu_addr (alu_addr),
    .i_alu_data (alu_data),
    .o_alu_gnt  (alu_gnt),
    .i_ld_req   (ld_req),
    .i_ld_addr  (ld_addr),
    .i_ld_data  (ld_data),
    .o_ld_gnt   (ld_gnt),
    .o_wr_en    (wr_en),
    .o_wr_data  (wr_data),
    .o_pend_cnt (pend_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic h,
                       input logic ar, input logic [3:0] aa, input logic [15:0] ad,
                       input logic lr, input logic [3:0] la, input logic [15:0] ld);
    hold     = h;
    alu_req  = ar;
    alu_addr = aa;
    alu_data = ad;
    ld_req   = lr;
    ld_addr  = la;
    ld_data  = ld;
  endtask

  // Advance one full cycle; returns at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_gnt(input string tag, input logic ea, input logic el);
    #1;
    chk({tag, "_alu_gnt"}, 32'(alu_gnt), 32'(ea));
    chk({tag, "_ld_gnt"},  32'(ld_gnt),  32'(el));
  endtask

  task automatic chk_out(input string tag, input logic [15:0] e_en,
                         input logic [15:0] e_data, input logic [1:0] e_pend);
    chk({tag, "_wr_en"},    32'(wr_en),    32'(e_en));
    chk({tag, "_wr_data"},  32'(wr_data),  32'(e_data));
    chk({tag, "_pend_cnt"}, 32'(pend_cnt), 32'(e_pend));
  endtask

  task automatic pulse_reset();
    drive(0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [15:0] rr_en [4] = '{16'h0002, 16'h0004, 16'h0002, 16'h0004};
  logic [15:0] rr_dat[4] = '{16'h0101, 16'h0202, 16'h0101, 16'h0202};
  logic        rr_alu[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    // Reset state; a pending request must not be granted while in reset.
    drive(0, 1, 4'd3, 16'h00A5, 0, 4'd0, 16'h0);
    @(negedge clk);
    chk_gnt("rst", 0, 0);
    chk_out("rst", 16'h0000, 16'h0000, 2'd0);

    // Single ALU request right after reset release.
    rst = 1'b0;
    chk_gnt("single_alu", 1, 0);
    tick();
    chk_out("single_alu", 16'h0008, 16'h00A5, 2'd0);

    // Write enable lasts one cycle only, data is held.
    drive(0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    tick();
    chk_out("single_alu_after", 16'h0000, 16'h00A5, 2'd0);

    // Round-robin with both requesting continuously from reset.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 4'd1, 16'h0101, 1, 4'd2, 16'h0202);
      chk_gnt($sformatf("rr%0d", i), rr_alu[i], !rr_alu[i]);
      tick();
      chk_out($sformatf("rr%0d", i), rr_en[i], rr_dat[i], 2'd1);
    end

    // Idle cycle: no enable, data holds.
    drive(0, 0, 4'd1, 16'h0A11, 0, 4'd2, 16'h0BEE);
    chk_gnt("idle", 0, 0);
    tick();
    chk_out("idle", 16'h0000, 16'h0202, 2'd0);

    // Hold stalls a waiting load for three cycles.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 4'd0, 16'h0, 1, 4'd4, 16'h1234);
      chk_gnt($sformatf("hold%0d", i), 0, 0);
      tick();
      chk_out($sformatf("hold%0d", i), 16'h0000, 16'h0202, 2'd1);
    end
    drive(0, 0, 4'd0, 16'h0, 1, 4'd4, 16'h1234);
    chk_gnt("hold_release", 0, 1);
    tick();
    chk_out("hold_release", 16'h0010, 16'h1234, 2'd0);

    // Hold with both requesting counts two waiting.
    drive(1, 1, 4'd6, 16'h0666, 1, 4'd7, 16'h0777);
    chk_gnt("hold_both", 0, 0);
    tick();
    chk_out("hold_both", 16'h0000, 16'h1234, 2'd2);

    // Locked register 0: granted, no enable, data still captured.
    drive(0, 1, 4'd0, 16'hFFFF, 0, 4'd0, 16'h0);
    chk_gnt("lock_r0", 1, 0);
    tick();
    chk_out("lock_r0", 16'h0000, 16'hFFFF, 2'd0);

    // Single load to the top register also moves the pointer to LOAD.
    drive(0, 0, 4'd0, 16'h0, 1, 4'd15, 16'h0F0F);
    chk_gnt("ld_top", 0, 1);
    tick();
    chk_out("ld_top", 16'h8000, 16'h0F0F, 2'd0);

    // Same-address collision: ALU first (pointer=LOAD), then load.
    drive(0, 1, 4'd5, 16'h1111, 1, 4'd5, 16'h2222);
    chk_gnt("same_addr0", 1, 0);
    tick();
    chk_out("same_addr0", 16'h0020, 16'h1111, 2'd1);
    drive(0, 0, 4'd0, 16'h0, 1, 4'd5, 16'h2222);
    chk_gnt("same_addr1", 0, 1);
    tick();
    chk_out("same_addr1", 16'h0020, 16'h2222, 2'd0);

    // Reset asserted during a grant cycle discards the write.
    drive(0, 0, 4'd0, 16'h0, 1, 4'd7, 16'h7777);
    chk_gnt("rst_mid_pre", 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_gnt", 32'(ld_gnt), 32'd0);
    tick();
    chk_out("rst_mid", 16'h0000, 16'h0000, 2'd0);
    rst = 1'b0;
    drive(0, 1, 4'd1, 16'h0ABC, 1, 4'd2, 16'h0DEF);
    chk_gnt("rst_mid_tie", 1, 0);
    tick();
    chk_out("rst_mid_tie", 16'h0002, 16'h0ABC, 2'd1);

    drive(0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, data width of a register-bank entry.
REQ-002 Parameter NREG, default 16, number of register-bank entries; address width is log2(NREG).
REQ-003 Parameter LOCK_R0, default 1, when 1 writes to address 0 are granted but suppressed.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 hold  input  1  stall from sequencer; when 1, no grant is issued.
REQ-007 alu_req, alu_addr, alu_data  input  1/log2(NREG)/WIDTH  ALU writeback request, target and value.
REQ-008 alu_gnt  output  1  ALU request accepted this cycle.
REQ-009 ld_req, ld_addr, ld_data  input  1/log2(NREG)/WIDTH  memory-load writeback request, target and value.
REQ-010 ld_gnt  output  1  load request accepted this cycle.
REQ-011 wr_en  output  NREG  one-hot per-register enable driving each bank register's en input.
REQ-012 wr_data  output  WIDTH  value broadcast to all bank registers' data inputs.
REQ-013 pend_cnt  output  2  number of requests currently waiting (0..2).

Function
REQ-014 Requesters hold req, addr, data stable from req rise until the cycle gnt is 1; req may drop the cycle after gnt.
REQ-015 alu_gnt and ld_gnt are combinational from req, hold and arbitration state, and are never 1 together.
REQ-016 With hold=0 and exactly one req, that requester is granted the same cycle.
REQ-017 With hold=0 and both req, the requester NOT granted most recently wins (round-robin); the last-grant pointer updates only on a grant.
REQ-018 With hold=1, both gnt are 0 and wr_en is all-zero on the next edge; pointer unchanged.
REQ-019 Write latency is one cycle: on the edge ending a grant cycle, wr_en gets the one-hot of the granted addr and wr_data the granted data; both valid for exactly one cycle.
REQ-020 With no grant, wr_en registers to all-zero; wr_data holds its previous value.
REQ-021 If LOCK_R0=1 and the granted addr is 0, the grant still occurs but wr_en registers to all-zero.
REQ-022 Both requesters targeting the same address are serialized in round-robin order; the later grant's data is the final bank value.
REQ-023 Address >= NREG (non-power-of-two NREG) is granted and suppressed like REQ-021.
REQ-024 pend_cnt equals the number of req inputs that are 1 and not granted this cycle, registered.
REQ-025 Internal FSM states IDLE (no write issued last cycle), WRITE (write issued), STALL (hold=1 with a req pending); transitions each edge from the current cycle's grant/hold/req; state is observable only through wr_en and pend_cnt.

Reset
REQ-026 On reset=1, asynchronously: wr_en=0, wr_data=0, pend_cnt=0, FSM=IDLE, last-grant pointer=LOAD (ALU wins the first tie).
REQ-027 Reset asserted mid-operation discards any grant of that cycle; no write reaches the bank.
REQ-028 gnt outputs are 0 while reset=1.

Structure
REQ-029 Shared package holds WIDTH/NREG defaults, requester id enum (REQ_ALU, REQ_LD) and FSM state enum.
REQ-030 Address-to-one-hot decode is a separate sub-module onehot_decode(addr, en, onehot), instantiated once.

Verification
REQ-031 Reset release, alu_req=1 addr=3 data=16'h00A5 -> alu_gnt=1 same cycle; next cycle wr_en=16'h0008, wr_data=16'h00A5.
REQ-032 Both req every cycle for 4 cycles after reset (alu addr=1, ld addr=2) -> grants ALU,LD,ALU,LD; wr_en 16'h0002,16'h0004,16'h0002,16'h0004.
REQ-033 hold=1 for 3 cycles with ld_req=1 -> ld_gnt=0, wr_en=0, pend_cnt=1 throughout; hold=0 -> ld_gnt=1, write next cycle.
REQ-034 LOCK_R0=1, alu_req addr=0 data=16'hFFFF -> alu_gnt=1; wr_en stays 0.
REQ-035 Both req addr=5, alu data=16'h1111, ld data=16'h2222, pointer=LOAD -> wr_data 16'h1111 then 16'h2222, wr_en=16'h0020 both cycles.
REQ-036 reset pulsed in a grant cycle (ld addr=7) -> wr_en=0 next edge, pend_cnt=0, next tie grants ALU.
